// File: rtl/bullet_scheduler.sv
// rtl/bullet_scheduler.sv - player bullet fire controller: edge-detected shots, round-robin slots, cooldown, magazine reload
module bullet_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int COOLDOWN  = 8,
    parameter int MAG_SIZE  = 8,
    parameter int RELOAD    = 90
) (
    input  logic                 clk_60hz,
    input  logic                 reset,
    input  logic                 shoot_up,
    input  logic                 shoot_down,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [NUM_SLOTS-1:0] kill,
    output logic                 dir,
    output logic [3:0]           ammo,
    output logic                 reloading,
    output logic [15:0]          shots_fired
);

    localparam int PTR_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_MAX = (RELOAD > COOLDOWN) ? RELOAD : COOLDOWN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_COOL   = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RELOAD - 1);
    localparam logic [3:0]       AMMO_FULL  = 4'(MAG_SIZE);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_COOLDOWN = 2'd1,
        S_RELOAD   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [PTR_W-1:0]     rr_ptr;
    logic                 prev_shoot;

    logic                 shoot;
    logic                 press;
    logic [NUM_SLOTS-1:0] free_mask;
    logic                 found;
    logic [PTR_W-1:0]     sel;
    logic [PTR_W-1:0]     idx;
    logic [NUM_SLOTS-1:0] grant;
    logic                 accept;
    logic [3:0]           ammo_after;
    logic [NUM_SLOTS-1:0] fire_next;
    logic [PTR_W-1:0]     rr_next;

    assign shoot      = shoot_up | shoot_down;
    assign press      = shoot & ~prev_shoot;
    // A slot granted last cycle has not raised its busy flag yet, so exclude it too.
    assign free_mask  = ~slot_busy & ~fire;
    assign ammo_after = ammo - 4'd1;
    assign grant      = found ? (NUM_SLOTS'(1) << sel) : '0;
    assign fire_next  = accept ? grant : '0;
    assign rr_next    = (sel == PTR_LAST) ? '0 : sel + PTR_W'(1);

    // Round-robin search: first free slot starting at rr_ptr, wrapping at NUM_SLOTS.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = rr_ptr;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && free_mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = (idx == PTR_LAST) ? '0 : idx + PTR_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_60hz or posedge reset) begin
        if (reset) begin
            state <= S_READY;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a shot leaves READY; the shared counter returns to READY.
    always_comb begin
        state_next = state;
        case (state)
            S_READY: begin
                if (accept) begin
                    state_next = (ammo_after == 4'd0) ? S_RELOAD : S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cnt == '0) begin
                    state_next = S_READY;
                end
            end
            S_RELOAD: begin
                if (cnt == '0) begin
                    state_next = S_READY;
                end
            end
            default: state_next = S_READY;
        endcase
    end

    // FSM outputs: a shot is taken only in READY with ammo and a free slot.
    always_comb begin
        accept    = 1'b0;
        reloading = 1'b0;
        case (state)
            S_READY:  accept    = press && (ammo != 4'd0) && found;
            S_RELOAD: reloading = 1'b1;
            default: begin
                accept    = 1'b0;
                reloading = 1'b0;
            end
        endcase
    end

    // Cooldown / reload frame counter, loaded on a shot and run down while blocked.
    always_ff @(posedge clk_60hz or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (ammo_after == 4'd0) ? CNT_RELOAD : CNT_COOL;
        end else if (state != S_READY && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Shot bookkeeping: fire/kill pulses, pointer, direction, ammo and shot counter.
    always_ff @(posedge clk_60hz or posedge reset) begin
        if (reset) begin
            fire        <= '0;
            kill        <= '0;
            dir         <= 1'b1;
            ammo        <= AMMO_FULL;
            shots_fired <= '0;
            rr_ptr      <= '0;
            prev_shoot  <= 1'b0;
        end else begin
            prev_shoot <= shoot;
            fire       <= fire_next;
            // Fire wins over a kill aimed at the same slot in the same cycle.
            kill       <= hit & slot_busy & ~fire_next;
            if (accept) begin
                ammo   <= ammo_after;
                rr_ptr <= rr_next;
                dir    <= shoot_up;
                if (shots_fired != 16'hFFFF) begin
                    shots_fired <= shots_fired + 16'd1;
                end
            end else if (state == S_RELOAD && cnt == '0) begin
                ammo <= AMMO_FULL;
            end
        end
    end

endmodule
